// File: rtl/fp_stream_acc.sv
// Streaming floating-point accumulator: sums one valid/ready group per in_last,
// rounding each step to nearest-even, and returns the sum with sticky flags and a count.
module fp_stream_acc #(
  parameter  int EXP_W = 5,
  parameter  int MAN_W = 10,
  parameter  int CNT_W = 8,
  localparam int W     = 1 + EXP_W + MAN_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_data,
  output logic [CNT_W-1:0] out_count,
  output logic             out_overflow,
  output logic             out_nan,
  output logic             out_inexact,
  output logic             out_zero
);

  localparam int unsigned L  = MAN_W + 4;
  localparam int          EW = EXP_W + 2;
  localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  typedef enum logic [0:0] {S_ACC, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [W-1:0]      acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              nan_q, nan_d, ovf_q, ovf_d, inx_q, inx_d;
  logic [W-1:0]      out_data_q, out_data_d;
  logic [CNT_W-1:0]  out_count_q, out_count_d;
  logic              out_ovf_q, out_ovf_d, out_nan_q, out_nan_d;
  logic              out_inx_q, out_inx_d, out_zero_q, out_zero_d;

  logic              a_sign, b_sign;
  logic [EXP_W-1:0]  a_exp, b_exp;
  logic [MAN_W-1:0]  a_man, b_man;
  logic              a_nan, b_nan, a_inf, b_inf;

  assign {a_sign, a_exp, a_man} = acc_q;
  assign {b_sign, b_exp, b_man} = in_data;
  assign a_nan = (a_exp == '1) && (a_man != '0);
  assign b_nan = (b_exp == '1) && (b_man != '0);
  assign a_inf = (a_exp == '1) && (a_man == '0);
  assign b_inf = (b_exp == '1) && (b_man == '0);

  logic              b_bigger, big_sign, eff_sub;
  logic [EXP_W-1:0]  big_exp, sm_exp, big_x, sm_x;
  logic [MAN_W:0]    big_sig, sm_sig;
  logic [31:0]       diff_ext, dsh, lz, limit, shamt;
  logic [2*L-1:0]    shifted;
  logic [L-1:0]      al_small, norm;
  logic [L:0]        sum;
  logic [EW-1:0]     e0, e1, e2;
  logic              rnd_g, rnd_r, rnd_s, rnd_up;
  logic [MAN_W+1:0]  mant;
  logic [MAN_W:0]    sig_f;
  logic [EXP_W-1:0]  exp_field;
  logic              fin_sign;
  logic [W-1:0]      step_res;
  logic              step_nan, step_ovf, step_inx;

  // Datapath for one accumulate step: align, add/sub, normalise, round, then specials.
  always_comb begin
    b_bigger = {b_exp, b_man} > {a_exp, a_man};
    big_sign = b_bigger ? b_sign : a_sign;
    big_exp  = b_bigger ? b_exp  : a_exp;
    sm_exp   = b_bigger ? a_exp  : b_exp;
    big_sig  = b_bigger ? {b_exp != '0, b_man} : {a_exp != '0, a_man};
    sm_sig   = b_bigger ? {a_exp != '0, a_man} : {b_exp != '0, b_man};
    eff_sub  = a_sign != b_sign;
    big_x    = (big_exp == '0) ? EXP_W'(1) : big_exp;
    sm_x     = (sm_exp  == '0) ? EXP_W'(1) : sm_exp;

    diff_ext = 32'(big_x) - 32'(sm_x);
    dsh      = (diff_ext > L) ? L : diff_ext;
    shifted  = {sm_sig, 3'b000, {L{1'b0}}} >> dsh;
    al_small = {shifted[2*L-1:L+1], shifted[L] | (|shifted[L-1:0])};

    if (eff_sub) sum = {1'b0, big_sig, 3'b000} - {1'b0, al_small};
    else         sum = {1'b0, big_sig, 3'b000} + {1'b0, al_small};

    e0 = {2'b00, big_x};
    lz = L;
    for (int i = 0; i < int'(L); i++) begin
      if (sum[i]) lz = L - 1 - i;
    end
    limit = 32'(e0) - 32'd1;
    shamt = (lz < limit) ? lz : limit;
    // Left shifts stop at the subnormal exponent so tiny results stay denormalised.
    if (sum[L]) begin
      norm = {sum[L:2], sum[1] | sum[0]};
      e1   = e0 + EW'(1);
    end else begin
      norm = sum[L-1:0] << shamt;
      e1   = e0 - EW'(shamt);
    end

    rnd_g  = norm[2];
    rnd_r  = norm[1];
    rnd_s  = norm[0];
    rnd_up = rnd_g & (rnd_r | rnd_s | norm[3]);
    mant   = {1'b0, norm[L-1:3]} + (MAN_W+2)'(rnd_up);
    if (mant[MAN_W+1]) begin
      sig_f = mant[MAN_W+1:1];
      e2    = e1 + EW'(1);
    end else begin
      sig_f = mant[MAN_W:0];
      e2    = e1;
    end
    exp_field = sig_f[MAN_W] ? e2[EXP_W-1:0] : '0;
    fin_sign  = (eff_sub && (sig_f == '0)) ? 1'b0 : big_sign;

    step_nan = 1'b0;
    step_ovf = 1'b0;
    step_inx = 1'b0;
    if (a_nan || b_nan || (a_inf && b_inf && eff_sub)) begin
      step_res = QNAN;
      step_nan = 1'b1;
      step_ovf = a_inf | b_inf;
    end else if (a_inf || b_inf) begin
      step_res = a_inf ? acc_q : in_data;
      step_ovf = 1'b1;
    end else if (sig_f[MAN_W] && (e2 >= {2'b00, {EXP_W{1'b1}}})) begin
      step_res = {big_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      step_ovf = 1'b1;
      step_inx = 1'b1;
    end else begin
      step_res = {fin_sign, exp_field, sig_f[MAN_W-1:0]};
      step_inx = rnd_g | rnd_r | rnd_s;
    end
  end

  logic             fire;
  logic [CNT_W-1:0] cnt_inc;

  assign in_ready  = (state_q == S_ACC) && !reset;
  assign out_valid = (state_q == S_DONE);
  assign fire      = in_valid && in_ready;
  assign cnt_inc   = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);

  // Group control: accumulate in ACC, publish on in_last, hold the result in DONE.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    nan_d       = nan_q;
    ovf_d       = ovf_q;
    inx_d       = inx_q;
    out_data_d  = out_data_q;
    out_count_d = out_count_q;
    out_ovf_d   = out_ovf_q;
    out_nan_d   = out_nan_q;
    out_inx_d   = out_inx_q;
    out_zero_d  = out_zero_q;
    case (state_q)
      S_ACC: begin
        if (fire) begin
          if (in_last) begin
            out_data_d  = step_res;
            out_count_d = cnt_inc;
            out_ovf_d   = ovf_q | step_ovf;
            out_nan_d   = nan_q | step_nan;
            out_inx_d   = inx_q | step_inx;
            out_zero_d  = step_res[W-2:0] == '0;
            acc_d       = '0;
            cnt_d       = '0;
            nan_d       = 1'b0;
            ovf_d       = 1'b0;
            inx_d       = 1'b0;
            state_d     = S_DONE;
          end else begin
            acc_d = step_res;
            cnt_d = cnt_inc;
            nan_d = nan_q | step_nan;
            ovf_d = ovf_q | step_ovf;
            inx_d = inx_q | step_inx;
          end
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_ACC;
      end
      default: state_d = S_ACC;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_ACC;
      acc_q       <= '0;
      cnt_q       <= '0;
      nan_q       <= 1'b0;
      ovf_q       <= 1'b0;
      inx_q       <= 1'b0;
      out_data_q  <= '0;
      out_count_q <= '0;
      out_ovf_q   <= 1'b0;
      out_nan_q   <= 1'b0;
      out_inx_q   <= 1'b0;
      out_zero_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      nan_q       <= nan_d;
      ovf_q       <= ovf_d;
      inx_q       <= inx_d;
      out_data_q  <= out_data_d;
      out_count_q <= out_count_d;
      out_ovf_q   <= out_ovf_d;
      out_nan_q   <= out_nan_d;
      out_inx_q   <= out_inx_d;
      out_zero_q  <= out_zero_d;
    end
  end

  assign out_data     = out_data_q;
  assign out_count    = out_count_q;
  assign out_overflow = out_ovf_q;
  assign out_nan      = out_nan_q;
  assign out_inexact  = out_inx_q;
  assign out_zero     = out_zero_q;

endmodule

// File: tb/tb_fp_stream_acc.sv
// Directed bench for fp_stream_acc at fp16 defaults; expected sums are hand-computed.
module tb_fp_stream_acc;
  localparam int EXP_W = 5;
  localparam int MAN_W = 10;
  localparam int CNT_W = 8;
  localparam int W     = 1 + EXP_W + MAN_W;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid, in_ready, in_last;
  logic [W-1:0]     in_data;
  logic             out_valid, out_ready;
  logic [W-1:0]     out_data;
  logic [CNT_W-1:0] out_count;
  logic             out_overflow, out_nan, out_inexact, out_zero;
  logic [3:0]       flags;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  assign flags = {out_overflow, out_nan, out_inexact, out_zero};

  fp_stream_acc #(.EXP_W(EXP_W), .MAN_W(MAN_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_count(out_count), .out_overflow(out_overflow), .out_nan(out_nan),
    .out_inexact(out_inexact), .out_zero(out_zero)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One operand per call: held for exactly one rising edge, then dropped.
  task automatic applyStimulus(input logic [W-1:0] d, input logic last);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = '0;
  endtask

  task automatic checkGroup(input string tag, input logic [W-1:0] exp_data,
                            input logic [CNT_W-1:0] exp_cnt, input logic [3:0] exp_flags);
    checkOutput({tag, ".valid"}, 32'(out_valid), 32'd1);
    checkOutput({tag, ".data"},  32'(out_data),  32'(exp_data));
    checkOutput({tag, ".count"}, 32'(out_count), 32'(exp_cnt));
    checkOutput({tag, ".flags"}, 32'(flags),     32'(exp_flags));
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    checkOutput({tag, ".ready_after"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst.ready", 32'(in_ready), 32'd0);
    checkOutput("rst.valid", 32'(out_valid), 32'd0);
    checkOutput("rst.data", 32'(out_data), 32'd0);
    checkOutput("rst.flags", 32'(flags), 32'd0);
    reset = 1'b0;
    #1;
    checkOutput("rst.ready_release", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;

    applyStimulus(16'h3C00, 1'b0);
    checkOutput("g1.not_yet", 32'(out_valid), 32'd0);
    applyStimulus(16'h4000, 1'b1);
    checkGroup("g1", 16'h4200, 8'd2, 4'b0000);

    applyStimulus(16'h3C00, 1'b0);
    in_last = 1'b1;
    @(posedge clk);
    #1;
    in_last = 1'b0;
    checkOutput("g2.last_no_valid", 32'(out_valid), 32'd0);
    applyStimulus(16'h1000, 1'b1);
    checkGroup("g2_tie", 16'h3C00, 8'd2, 4'b0010);

    applyStimulus(16'h3C00, 1'b0);
    applyStimulus(16'h1400, 1'b1);
    checkGroup("g3_ulp", 16'h3C01, 8'd2, 4'b0000);

    applyStimulus(16'h7BFF, 1'b0);
    applyStimulus(16'h7BFF, 1'b1);
    checkGroup("g4_ovf", 16'h7C00, 8'd2, 4'b1010);

    applyStimulus(16'h7C00, 1'b0);
    applyStimulus(16'hFC00, 1'b1);
    checkGroup("g5_infnan", 16'h7E00, 8'd2, 4'b1100);

    applyStimulus(16'h0001, 1'b0);
    applyStimulus(16'h0001, 1'b0);
    applyStimulus(16'h03FF, 1'b1);
    checkGroup("g6_subn", 16'h0401, 8'd3, 4'b0000);

    applyStimulus(16'h3C00, 1'b0);
    applyStimulus(16'hBC00, 1'b1);
    checkGroup("g7_cancel", 16'h0000, 8'd2, 4'b0001);

    applyStimulus(16'h8000, 1'b1);
    checkGroup("g8_negzero", 16'h0000, 8'd1, 4'b0001);

    applyStimulus(16'h7E01, 1'b0);
    applyStimulus(16'h3C00, 1'b1);
    checkGroup("g9_nanpersist", 16'h7E00, 8'd2, 4'b0100);

    // Result held under backpressure while the producer keeps offering data.
    applyStimulus(16'h3C00, 1'b0);
    applyStimulus(16'h3C00, 1'b1);
    in_valid = 1'b1;
    in_data  = 16'h4000;
    for (int k = 0; k < 5; k++) begin
      checkOutput("hold.valid", 32'(out_valid), 32'd1);
      checkOutput("hold.ready", 32'(in_ready), 32'd0);
      checkOutput("hold.data", 32'(out_data), 32'h4000);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    in_data  = '0;
    checkGroup("hold", 16'h4000, 8'd2, 4'b0000);
    applyStimulus(16'h3800, 1'b1);
    checkGroup("after_hold", 16'h3800, 8'd1, 4'b0000);

    applyStimulus(16'h7E01, 1'b1);
    checkGroup("pre_rst", 16'h7E00, 8'd1, 4'b0100);
    applyStimulus(16'h3C00, 1'b0);
    applyStimulus(16'h3C00, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("midrst.data", 32'(out_data), 32'd0);
    checkOutput("midrst.flags", 32'(flags), 32'd0);
    checkOutput("midrst.count", 32'(out_count), 32'd0);
    checkOutput("midrst.ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    applyStimulus(16'h3C00, 1'b0);
    applyStimulus(16'h3C00, 1'b1);
    checkGroup("post_rst", 16'h4000, 8'd2, 4'b0000);

    for (int k = 0; k < 299; k++) applyStimulus(16'h0000, 1'b0);
    applyStimulus(16'h0000, 1'b1);
    checkGroup("sat", 16'h0000, 8'd255, 4'b0001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
